// File: rtl/VX_gpu_pkg.sv
// Shared definitions for the cache flush scheduler: FSM state encoding
// and the default uuid width forwarded to the cache banks.
package VX_gpu_pkg;

  // Width of the flush/request uuid tag.
  localparam int UUID_WIDTH = 16;

  // Flush sequencing states.
  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_DRAIN = 3'd1,
    FS_FLUSH = 3'd2,
    FS_WAIT  = 3'd3,
    FS_DONE  = 3'd4
  } flush_state_e;

endpackage

// File: rtl/cache_flush_rr_pick.sv
// Combinational round-robin picker: scans req_i starting at rr_ptr_i and
// returns the first requester found as a one-hot grant plus its index.
module cache_flush_rr_pick
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [IDX_W-1:0]    rr_ptr_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [IDX_W-1:0]    grant_idx_o,
  output logic                grant_valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    cand          = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    grant_o       = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr_i) + i) % NUM_REQS);
      if (req_i[cand]) begin
        grant_idx_o   = cand;
        grant_valid_o = 1'b1;
      end
    end
    grant_o[grant_idx_o] = grant_valid_o;
  end

endmodule

// File: rtl/cache_flush_sched.sv
// Cache flush scheduler: arbitrates flush requests, drains the banks,
// pulses flush_begin, collects flush_end from every bank and acks the
// served requester(s).
// Build option: define CACHE_FLUSH_COALESCE_EN to let one flush satisfy
// every requester valid in the arbitration cycle.
module cache_flush_sched
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int NUM_BANKS = 1,
  parameter int UUID_W    = (UUID_WIDTH > 0) ? UUID_WIDTH : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQS-1:0]        flush_req_valid,
  input  logic [NUM_REQS*UUID_W-1:0] flush_req_uuid,
  output logic [NUM_REQS-1:0]        flush_req_ready,
  input  logic [NUM_BANKS-1:0]       bank_idle,
  output logic [NUM_BANKS-1:0]       flush_begin,
  output logic [UUID_W-1:0]          flush_uuid,
  input  logic [NUM_BANKS-1:0]       flush_end,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  flush_state_e         state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic [NUM_REQS-1:0]  served_q;
  logic [NUM_BANKS-1:0] done_q;
  logic [UUID_W-1:0]    flush_uuid_q;
  logic [NUM_BANKS-1:0] flush_begin_q;
  logic [NUM_REQS-1:0]  ready_q;
  logic                 busy_q;

  logic [NUM_REQS-1:0]  pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [NUM_REQS-1:0]  served_d;
  logic [NUM_BANKS-1:0] done_d;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [UUID_W-1:0]    uuid_arr [NUM_REQS];

  // Split the flat uuid bus into one entry per requester.
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_uuid
    assign uuid_arr[gi] = flush_req_uuid[gi*UUID_W +: UUID_W];
  end

  cache_flush_rr_pick #(
    .NUM_REQS (NUM_REQS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req_i         (flush_req_valid),
    .rr_ptr_i      (rr_ptr_q),
    .grant_o       (pick_grant),
    .grant_idx_o   (pick_idx),
    .grant_valid_o (pick_valid)
  );

  // Served set, bank completion accumulation and pointer advance past the granted requester.
  always_comb begin
`ifdef CACHE_FLUSH_COALESCE_EN
    served_d = flush_req_valid | pick_grant;
`else
    served_d = pick_grant;
`endif
    done_d   = done_q | flush_end;
    rr_ptr_d = (int'(grant_idx_q) == NUM_REQS - 1) ? '0 : grant_idx_q + 1'b1;
  end

  // Flush sequencing FSM with registered pulse/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= FS_IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      served_q      <= '0;
      done_q        <= '0;
      flush_uuid_q  <= '0;
      flush_begin_q <= '0;
      ready_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      flush_begin_q <= '0;
      ready_q       <= '0;
      case (state_q)
        FS_IDLE: begin
          if (pick_valid) begin
            served_q     <= served_d;
            grant_idx_q  <= pick_idx;
            flush_uuid_q <= uuid_arr[pick_idx];
            busy_q       <= 1'b1;
            state_q      <= FS_DRAIN;
          end
        end
        FS_DRAIN: begin
          if (&bank_idle) begin
            flush_begin_q <= '1;
            state_q       <= FS_FLUSH;
          end
        end
        FS_FLUSH: begin
          // A bank may complete in the same cycle it sees flush_begin.
          done_q  <= done_d;
          state_q <= FS_WAIT;
        end
        FS_WAIT: begin
          if (&done_d) begin
            done_q  <= '0;
            ready_q <= served_q;
            state_q <= FS_DONE;
          end else begin
            done_q <= done_d;
          end
        end
        FS_DONE: begin
          rr_ptr_q <= rr_ptr_d;
          served_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= FS_IDLE;
        end
        default: begin
          state_q <= FS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flush_req_ready = ready_q;
  assign flush_begin     = flush_begin_q;
  assign flush_uuid      = flush_uuid_q;
  assign busy            = busy_q;

`ifndef SYNTHESIS
  // A served requester must keep valid high until it is acked.
  a_served_hold: assert property (@(posedge clk) disable iff (reset)
    (state_q != FS_IDLE) |-> ((served_q & ~flush_req_valid) == '0));

  // Banks only report completion while a flush is outstanding.
  a_end_window: assert property (@(posedge clk) disable iff (reset)
    (|flush_end) |-> (state_q == FS_FLUSH || state_q == FS_WAIT));
`endif

endmodule

// File: tb/tb_cache_flush_sched.sv
// Scoreboard bench for cache_flush_sched: stimulus pushes expected
// flush_begin / flush_req_ready events, a negedge monitor pops and compares.
module tb_cache_flush_sched;

  localparam int NR = 4;
  localparam int NB = 2;
  localparam int UW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   flush_req_valid = '0;
  logic [NR*UW-1:0] flush_req_uuid;
  logic [NR-1:0]   flush_req_ready;
  logic [NB-1:0]   bank_idle = '1;
  logic [NB-1:0]   flush_begin;
  logic [UW-1:0]   flush_uuid;
  logic [NB-1:0]   flush_end;
  logic            busy;

  logic [UW-1:0]   uuid_arr [NR];
  logic [NB-1:0]   man_fe = '0;
  logic [NB-1:0]   auto_fe = '0;
  bit              auto_end = 1'b0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_ready;
    logic [3:0] mask;
    logic [7:0] uuid;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  assign flush_req_uuid = {uuid_arr[3], uuid_arr[2], uuid_arr[1], uuid_arr[0]};
  assign flush_end      = man_fe | auto_fe;

  cache_flush_sched #(
    .NUM_REQS  (NR),
    .NUM_BANKS (NB),
    .UUID_W    (UW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush_req_valid (flush_req_valid),
    .flush_req_uuid  (flush_req_uuid),
    .flush_req_ready (flush_req_ready),
    .bank_idle       (bank_idle),
    .flush_begin     (flush_begin),
    .flush_uuid      (flush_uuid),
    .flush_end       (flush_end),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(bit r, logic [3:0] m, logic [7:0] u, int c);
    ev_t e;
    e.is_ready = r;
    e.mask     = m;
    e.uuid     = u;
    e.cyc      = c;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(bit r, logic [3:0] m);
    ev_t e;
    if (exp_q.size() == 0) begin
      check(r ? "unexpected_ready" : "unexpected_begin", 32'(m), 32'h0);
    end else begin
      e = exp_q.pop_front();
      check(r ? "ready_kind" : "begin_kind", 32'(r), 32'(e.is_ready));
      check(r ? "ready_mask" : "begin_mask", 32'(m), 32'(e.mask));
      check(r ? "ready_uuid" : "begin_uuid", 32'(flush_uuid), 32'(e.uuid));
      check(r ? "ready_cycle" : "begin_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitor: compare every observed begin/ready pulse against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (flush_begin != '0) pop_cmp(1'b0, {2'b00, flush_begin});
      if (flush_req_ready != '0) pop_cmp(1'b1, flush_req_ready);
    end
  end

  // Bank model: answer each flush_begin with flush_end on both banks one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_end && flush_begin != '0) begin
        @(posedge clk); #1 auto_fe = 2'b11;
        @(posedge clk); #1 auto_fe = 2'b00;
      end
    end
  end

  // Advance to 1 time unit after the posedge that starts cycle n.
  task automatic go(int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    for (int i = 0; i < NR; i++) uuid_arr[i] = '0;

    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_begin", 32'(flush_begin), 32'h0);
    check("rst_ready", 32'(flush_req_ready), 32'h0);
    check("rst_uuid", 32'(flush_uuid), 32'h0);
    #21 reset = 1'b0;
    @(posedge clk); #1;

    // Fairness: all four valid continuously, acks 0,1,2,3,0
    auto_end = 1'b1;
    for (int i = 0; i < NR; i++) uuid_arr[i] = 8'h40 + 8'(i);
    b = cyc;
    for (int k = 0; k < 5; k++) begin
      push_ev(1'b0, 4'b0011, 8'h40 + 8'(k % 4), b + 2 + 5*k);
      push_ev(1'b1, 4'b0001 << (k % 4), 8'h40 + 8'(k % 4), b + 4 + 5*k);
    end
    flush_req_valid = 4'b1111;
    go(b + 25);
    flush_req_valid = '0;
    go(b + 27);

    // Coalesce scenario: valid=1011 with rr_ptr=1
    uuid_arr[0] = 8'h50; uuid_arr[1] = 8'h51; uuid_arr[3] = 8'h53;
    b = cyc;
`ifdef CACHE_FLUSH_COALESCE_EN
    push_ev(1'b0, 4'b0011, 8'h51, b + 2);
    push_ev(1'b1, 4'b1011, 8'h51, b + 4);
    flush_req_valid = 4'b1011;
    go(b + 5);
`else
    push_ev(1'b0, 4'b0011, 8'h51, b + 2);
    push_ev(1'b1, 4'b0010, 8'h51, b + 4);
    push_ev(1'b0, 4'b0011, 8'h53, b + 7);
    push_ev(1'b1, 4'b1000, 8'h53, b + 9);
    push_ev(1'b0, 4'b0011, 8'h50, b + 12);
    push_ev(1'b1, 4'b0001, 8'h50, b + 14);
    flush_req_valid = 4'b1011;
    go(b + 15);
`endif
    flush_req_valid = '0;
    go(cyc + 2);
    check("coal_idle", 32'(busy), 32'h0);
    auto_end = 1'b0;

    // Single requester, best-case latency
    uuid_arr[2] = 8'h15;
    b = cyc;
    push_ev(1'b0, 4'b0011, 8'h15, b + 2);
    push_ev(1'b1, 4'b0100, 8'h15, b + 4);
    flush_req_valid = 4'b0100;
    go(b + 1);
    check("t1_busy_drain", 32'(busy), 32'h1);
    go(b + 3); man_fe = 2'b11;
    go(b + 4); man_fe = 2'b00;
    go(b + 5); flush_req_valid = '0;
    check("t1_busy_after", 32'(busy), 32'h0);
    go(b + 7);

    // Drain stall: bank 1 busy for five cycles
    uuid_arr[0] = 8'h21;
    b = cyc;
    push_ev(1'b0, 4'b0011, 8'h21, b + 6);
    push_ev(1'b1, 4'b0001, 8'h21, b + 8);
    flush_req_valid = 4'b0001;
    bank_idle = 2'b01;
    go(b + 5); bank_idle = 2'b11;
    check("t2_busy_stall", 32'(busy), 32'h1);
    go(b + 7); man_fe = 2'b11;
    go(b + 8); man_fe = 2'b00;
    go(b + 9); flush_req_valid = '0;
    go(b + 11);

    // Staggered flush_end from the two banks
    uuid_arr[1] = 8'h33;
    b = cyc;
    push_ev(1'b0, 4'b0011, 8'h33, b + 2);
    push_ev(1'b1, 4'b0010, 8'h33, b + 8);
    flush_req_valid = 4'b0010;
    go(b + 3); man_fe = 2'b01;
    go(b + 4); man_fe = 2'b00;
    go(b + 7); man_fe = 2'b10;
    check("t3_busy_wait", 32'(busy), 32'h1);
    go(b + 8); man_fe = 2'b00;
    go(b + 9); flush_req_valid = '0;
    go(b + 11);

    // Async reset during WAIT, then a fresh flush from rr_ptr=0
    uuid_arr[2] = 8'h66; uuid_arr[0] = 8'h60;
    b = cyc;
    push_ev(1'b0, 4'b0011, 8'h66, b + 2);
    flush_req_valid = 4'b0100;
    go(b + 3);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_begin", 32'(flush_begin), 32'h0);
    check("t6_rst_ready", 32'(flush_req_ready), 32'h0);
    check("t6_rst_uuid", 32'(flush_uuid), 32'h0);
    flush_req_valid = 4'b0101;
    push_ev(1'b0, 4'b0011, 8'h60, b + 7);
    push_ev(1'b1, 4'b0001, 8'h60, b + 9);
    go(b + 5); reset = 1'b0;
    go(b + 8); man_fe = 2'b11;
    go(b + 9); man_fe = 2'b00;
    go(b + 10); flush_req_valid = '0;
    go(b + 13);
    check("final_busy", 32'(busy), 32'h0);
    check("scoreboard_left", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
